// File: rtl/wb_slave_fabric.sv
// Wishbone classic slave that forwards to one of NUM_SLAVES downstream slaves,
// with a response timeout, an internal CSR block and a level interrupt.
module wb_slave_fabric #(
   parameter int unsigned NUM_SLAVES = 11,
   parameter int unsigned SEL_LSB    = 12,
   parameter logic [7:0]  BASE       = 8'h30,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_n_i,
   input  logic                       wbs_stb_i,
   input  logic                       wbs_cyc_i,
   input  logic                       wbs_we_i,
   input  logic [3:0]                 wbs_sel_i,
   input  logic [31:0]                wbs_dat_i,
   input  logic [31:0]                wbs_adr_i,
   output logic                       wbs_ack_o,
   output logic [31:0]                wbs_dat_o,
   output logic [NUM_SLAVES-1:0]      m_wbs_stb_o,
   input  logic [NUM_SLAVES-1:0]      m_wbs_ack_i,
   input  logic [32*NUM_SLAVES-1:0]   m_wbs_dat_i,
   output logic [NUM_SLAVES-1:0]      m_rst_o,
   output logic                       irq_o
);

   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 10;
   localparam int unsigned DW    = 32;

   localparam logic [DW-1:0] TO_DATA = 32'hDEAD_DEAD;
   localparam logic [DW-1:0] UM_DATA = 32'hBAD0_0000;

   typedef enum logic [1:0] {IDLE, FWD, RESP} state_e;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  we_q, we_d;
   logic                  csr_q, csr_d;
   logic [1:0]            off_q, off_d;
   logic [DW-1:0]         wdat_q, wdat_d;
   logic [3:0]            sel_q, sel_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ack_q, ack_d;
   logic [DW-1:0]         dat_q, dat_d;
   logic [NUM_SLAVES-1:0] slv_rst_q, slv_rst_d;
   logic                  to_q, to_d, um_q, um_d;
   logic [IDX_W-1:0]      last_idx_q, last_idx_d;
   logic [1:0]            irq_en_q, irq_en_d;
   logic                  irq_q, irq_d;

   logic                  req_valid;
   logic [IDX_W-1:0]      req_idx;
   logic [DW-1:0]         csr_rdata;
   logic                  sel_ack;
   logic [DW-1:0]         sel_dat;
   logic                  set_to, set_um, clr_to, clr_um;
   logic                  unused_bits;

   assign req_valid   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == BASE);
   assign req_idx     = wbs_adr_i[SEL_LSB +: IDX_W];
   assign unused_bits = ^{wbs_adr_i, wdat_q, sel_q};

   // CSR read mux, evaluated at acceptance against the current register state
   always_comb begin
      csr_rdata = '0;
      case (wbs_adr_i[3:2])
         2'd0:    csr_rdata = DW'(slv_rst_q);
         2'd1:    csr_rdata = {20'b0, last_idx_q, 6'b0, um_q, to_q};
         2'd2:    csr_rdata = {30'b0, irq_en_q};
         default: csr_rdata = {8'hA5, 8'(NUM_SLAVES), 16'h0001};
      endcase
   end

   // Response and strobe of the currently selected slave
   always_comb begin
      sel_ack     = 1'b0;
      sel_dat     = '0;
      m_wbs_stb_o = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_ack = m_wbs_ack_i[i];
            sel_dat = m_wbs_dat_i[DW*i +: DW];
            m_wbs_stb_o[i] = (state_q == FWD) & wbs_stb_i & wbs_cyc_i;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      we_d       = we_q;
      csr_d      = csr_q;
      off_d      = off_q;
      wdat_d     = wdat_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      ack_d      = 1'b0;
      dat_d      = '0;
      slv_rst_d  = slv_rst_q;
      irq_en_d   = irq_en_q;
      last_idx_d = last_idx_q;
      set_to     = 1'b0;
      set_um     = 1'b0;
      clr_to     = 1'b0;
      clr_um     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               idx_d  = req_idx;
               we_d   = wbs_we_i;
               off_d  = wbs_adr_i[3:2];
               wdat_d = wbs_dat_i;
               sel_d  = wbs_sel_i;
               cnt_d  = '0;
               csr_d  = 1'b0;
               if (DW'(req_idx) < NUM_SLAVES) begin
                  state_d = FWD;
               end else if (req_idx == 4'hF) begin
                  csr_d   = 1'b1;
                  state_d = RESP;
                  ack_d   = 1'b1;
                  dat_d   = csr_rdata;
               end else begin
                  set_um  = 1'b1;
                  state_d = RESP;
                  ack_d   = 1'b1;
                  dat_d   = UM_DATA;
               end
            end
         end
         FWD: begin
            // Master abort has priority over any slave response
            if (!wbs_cyc_i) begin
               state_d = IDLE;
            end else if (sel_ack) begin
               state_d = RESP;
               ack_d   = 1'b1;
               dat_d   = sel_dat;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d    = RESP;
               ack_d      = 1'b1;
               dat_d      = TO_DATA;
               set_to     = 1'b1;
               last_idx_d = idx_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
            // CSR writes commit with the ack so they are visible the cycle after it
            if (csr_q && we_q) begin
               case (off_q)
                  2'd0: begin
                     for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                        if (sel_q[2'(i >> 3)]) slv_rst_d[i] = wdat_q[i];
                     end
                  end
                  2'd1: begin
                     clr_to = sel_q[0] & wdat_q[0];
                     clr_um = sel_q[0] & wdat_q[1];
                  end
                  2'd2: begin
                     if (sel_q[0]) irq_en_d = wdat_q[1:0];
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
      to_d  = (to_q & ~clr_to) | set_to;
      um_d  = (um_q & ~clr_um) | set_um;
      irq_d = |({um_q, to_q} & irq_en_q);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         we_q       <= 1'b0;
         csr_q      <= 1'b0;
         off_q      <= '0;
         wdat_q     <= '0;
         sel_q      <= '0;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
         slv_rst_q  <= '0;
         to_q       <= 1'b0;
         um_q       <= 1'b0;
         last_idx_q <= '0;
         irq_en_q   <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         we_q       <= we_d;
         csr_q      <= csr_d;
         off_q      <= off_d;
         wdat_q     <= wdat_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         slv_rst_q  <= slv_rst_d;
         to_q       <= to_d;
         um_q       <= um_d;
         last_idx_q <= last_idx_d;
         irq_en_q   <= irq_en_d;
         irq_q      <= irq_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign irq_o     = irq_q;
   assign m_rst_o   = slv_rst_q | {NUM_SLAVES{~wb_rst_n_i}};

endmodule

// File: tb/tb_wb_slave_fabric.sv
// Randomized bench for wb_slave_fabric against a transaction-level model of
// the fabric's CSRs, decode and response latencies.
module tb_wb_slave_fabric;

   localparam int unsigned NS  = 11;
   localparam int unsigned TMO = 255;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            stb, cyc, we;
   logic [3:0]      sel;
   logic [31:0]     dat_w, adr;
   logic            ack_o;
   logic [31:0]     dat_o;
   logic [NS-1:0]   m_stb, m_ack, m_rst;
   logic [32*NS-1:0] m_dat;
   logic            irq;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [NS-1:0] md_slv;
   logic          md_to, md_um;
   logic [3:0]    md_last;
   logic [1:0]    md_en;
   logic          md_irq_resp;
   int            n_timeouts = 0;

   wb_slave_fabric dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (rst_n),
      .wbs_stb_i   (stb),
      .wbs_cyc_i   (cyc),
      .wbs_we_i    (we),
      .wbs_sel_i   (sel),
      .wbs_dat_i   (dat_w),
      .wbs_adr_i   (adr),
      .wbs_ack_o   (ack_o),
      .wbs_dat_o   (dat_o),
      .m_wbs_stb_o (m_stb),
      .m_wbs_ack_i (m_ack),
      .m_wbs_dat_i (m_dat),
      .m_rst_o     (m_rst),
      .irq_o       (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] md_csr_rd(input logic [1:0] off);
      case (off)
         2'd0:    return 32'(md_slv);
         2'd1:    return {20'b0, md_last, 6'b0, md_um, md_to};
         2'd2:    return {30'b0, md_en};
         default: return {8'hA5, 8'd11, 16'h0001};
      endcase
   endfunction

   function automatic logic md_irq();
      return |({md_um, md_to} & md_en);
   endfunction

   task automatic md_reset();
      md_slv = '0; md_to = 1'b0; md_um = 1'b0; md_last = '0; md_en = '0;
      md_irq_resp = 1'b0;
   endtask

   task automatic noise();
      m_ack = NS'($urandom);
      for (int i = 0; i < int'(NS); i++) m_dat[32*i +: 32] = $urandom;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"},  32'(ack_o), 32'd0);
      chk({tag, "_dat"},  dat_o, 32'd0);
      chk({tag, "_stb"},  32'(m_stb), 32'd0);
      chk({tag, "_irq"},  32'(irq), 32'd0);
      chk({tag, "_mrst"}, 32'(m_rst), 32'h7FF);
   endtask

   // One complete request; returns at the sampling point of the ack cycle
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] s, input int d, input logic [31:0] sdat);
      logic [3:0]  idx;
      logic [1:0]  off;
      int          lat;
      logic [31:0] exp_d;
      bit          is_slv, is_csr, timed_out, got;
      idx = a[15:12];
      off = a[3:2];
      is_slv = (idx < 4'(NS));
      is_csr = (idx == 4'hF);
      timed_out = 1'b0;
      if (is_slv) begin
         if (d >= 1 && d <= int'(TMO)) begin lat = d + 1; exp_d = sdat; end
         else begin lat = int'(TMO) + 1; exp_d = 32'hDEAD_DEAD; timed_out = 1'b1; end
      end else if (is_csr) begin
         lat = 1; exp_d = md_csr_rd(off);
      end else begin
         lat = 1; exp_d = 32'hBAD0_0000;
      end
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; adr = a; we = w; dat_w = wd; sel = s;
      noise();
      @(negedge clk);
      chk("accept_ack", 32'(ack_o), 32'd0);
      chk("accept_stb", 32'(m_stb), 32'd0);
      chk("accept_mrst", 32'(m_rst), 32'(md_slv));
      got = 1'b0;
      for (int c = 1; c <= lat + 2; c++) begin
         @(posedge clk); #1;
         noise();
         if (is_slv && c < lat) begin
            m_ack[idx] = (c == d);
            m_dat[32*idx +: 32] = sdat;
         end
         @(negedge clk);
         if (ack_o === 1'b1) begin
            chk("ack_latency", 32'(c), 32'(lat));
            chk("ack_data", dat_o, exp_d);
            got = 1'b1;
            break;
         end
         chk("dat_when_no_ack", dat_o, 32'd0);
         if (is_slv && c < lat) chk("fwd_stb", 32'(m_stb), 32'd1 << idx);
         else                   chk("stb_outside_fwd", 32'(m_stb), 32'd0);
      end
      if (!got) chk("ack_missing", 32'(ack_o), 32'd1);
      if (timed_out) begin md_to = 1'b1; md_last = idx; end
      if (!is_slv && !is_csr) md_um = 1'b1;
      md_irq_resp = md_irq();
      if (is_csr && w) begin
         case (off)
            2'd0: for (int i = 0; i < int'(NS); i++) if (s[i/8]) md_slv[i] = wd[i];
            2'd1: if (s[0]) begin
                     if (wd[0]) md_to = 1'b0;
                     if (wd[1]) md_um = 1'b0;
                  end
            2'd2: if (s[0]) md_en = wd[1:0];
            default: ;
         endcase
      end
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0; we = 1'b0; m_ack = '0;
      @(negedge clk);
      chk("post_ack", 32'(ack_o), 32'd0);
      chk("post_dat", dat_o, 32'd0);
      chk("post_mrst", 32'(m_rst), 32'(md_slv));
      chk("irq_after_resp", 32'(irq), 32'(md_irq_resp));
      @(posedge clk);
      @(negedge clk);
      chk("irq_settled", 32'(irq), 32'(md_irq()));
   endtask

   initial begin
      int idx, d, off;
      logic [31:0] a;
      rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0;
      dat_w = '0; adr = '0; m_ack = '0; m_dat = '0;
      md_reset();
      #1;
      chk_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("mrst_released", 32'(m_rst), 32'd0);

      // Slave 3 read acked in its second forwarded cycle
      xfer(32'h3000_3000, 1'b0, '0, 4'hF, 2, 32'h1234_5678);
      go_idle();

      // Timeout on slave 5 with TO interrupt enabled, then W1C
      xfer(32'h3000_F008, 1'b1, 32'h1, 4'b0001, 0, '0);
      go_idle();
      xfer(32'h3000_5000, 1'b0, '0, 4'hF, 0, '0);
      go_idle();
      chk("irq_after_timeout", 32'(irq), 32'd1);
      xfer(32'h3000_F004, 1'b0, '0, 4'hF, 0, '0);
      chk("status_after_timeout", dat_o, 32'h0000_0501);
      go_idle();
      xfer(32'h3000_F004, 1'b1, 32'h1, 4'b0001, 0, '0);
      go_idle();
      chk("irq_cleared", 32'(irq), 32'd0);

      // Ack in the very cycle the timeout would fire: ack wins
      xfer(32'h3000_7000, 1'b0, '0, 4'hF, int'(TMO), 32'hCAFE_F00D);
      go_idle();

      // Byte-lane masked SLV_RST writes
      xfer(32'h3000_F000, 1'b1, 32'h0000_0404, 4'b0001, 0, '0);
      go_idle();
      chk("mrst_written", 32'(m_rst), 32'h004);
      xfer(32'h3000_F000, 1'b1, 32'h0000_00FF, 4'b0010, 0, '0);
      go_idle();
      xfer(32'h3000_F000, 1'b0, '0, 4'hF, 0, '0);
      go_idle();

      // Unmapped slot and ID register
      xfer(32'h3000_C000, 1'b0, '0, 4'hF, 0, '0);
      xfer(32'h3000_F00C, 1'b0, '0, 4'hF, 0, '0);
      chk("id_value", dat_o, 32'hA50B_0001);
      go_idle();

      // Request outside the fabric's base is never accepted
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3100_2000;
      repeat (3) begin
         @(negedge clk);
         chk("foreign_ack", 32'(ack_o), 32'd0);
         chk("foreign_stb", 32'(m_stb), 32'd0);
      end
      go_idle();

      // Master abort in the third forwarded cycle
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_4000; m_ack = '0;
      repeat (3) @(posedge clk);
      #1 cyc = 1'b0;
      @(negedge clk);
      chk("abort_ack", 32'(ack_o), 32'd0);
      chk("abort_stb", 32'(m_stb), 32'd0);
      @(posedge clk); #1 stb = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_ack", 32'(ack_o), 32'd0);
         chk("abort_stb_idle", 32'(m_stb), 32'd0);
      end
      xfer(32'h3000_4000, 1'b0, '0, 4'hF, 1, 32'h0BAD_BEEF);
      go_idle();

      // Asynchronous reset in the middle of a forwarded transfer
      xfer(32'h3000_F008, 1'b1, 32'h2, 4'b0001, 0, '0);
      go_idle();
      xfer(32'h3000_E000, 1'b0, '0, 4'hF, 0, '0);
      go_idle();
      chk("irq_before_reset", 32'(irq), 32'd1);
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_2000; m_ack = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      stb = 1'b0; cyc = 1'b0;
      md_reset();
      @(negedge clk); rst_n = 1'b1;
      xfer(32'h3000_2000, 1'b0, '0, 4'hF, 3, 32'h5A5A_0002);
      go_idle();

      // Randomized traffic, mixing back-to-back and idle-separated requests
      for (int n = 0; n < 80; n++) begin
         idx = int'($urandom_range(0, 15));
         off = int'($urandom_range(0, 3));
         d   = int'($urandom_range(1, 6));
         if (idx < int'(NS) && n_timeouts < 3 && $urandom_range(0, 15) == 0) begin
            d = 0;
            n_timeouts++;
         end
         a = {8'h30, 8'($urandom), 4'(idx), 8'($urandom), 2'(off), 2'b00};
         xfer(a, 1'($urandom), $urandom, 4'($urandom), d, $urandom);
         if ($urandom_range(0, 2) != 0) go_idle();
      end
      go_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb_slave_fabric.md
WB_SLAVE_FABRIC -- requirements
Module: wb_slave_fabric

Interface
REQ-001 Parameter NUM_SLAVES, default 11, number of downstream slaves, legal range 1..15.
REQ-002 Parameter SEL_LSB, default 12, lowest wbs_adr_i bit of the 4-bit slave index field.
REQ-003 Parameter BASE, default 8'h30, required value of wbs_adr_i[31:24].
REQ-004 Parameter TIMEOUT, default 255, slave response timeout in cycles, legal range 8..1023.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 wb_clk_i  in  1  system clock; all logic is rising-edge.
REQ-007 wb_rst_n_i  in  1  asynchronous active-low reset.
REQ-008 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic master strobe, cycle and write enable.
REQ-009 wbs_sel_i  in  4  byte-lane select; wbs_dat_i  in  32  write data; wbs_adr_i  in  32  address.
REQ-010 wbs_ack_o  out  1  transfer acknowledge; wbs_dat_o  out  32  read data.
REQ-011 m_wbs_stb_o  out  NUM_SLAVES  per-slave strobe; m_wbs_ack_i  in  NUM_SLAVES  per-slave acknowledge.
REQ-012 m_wbs_dat_i  in  32*NUM_SLAVES  slave read data, slave i on bits [32i+31:32i].
REQ-013 m_rst_o  out  NUM_SLAVES  active-high per-slave reset; irq_o  out  1  level interrupt.

Function
REQ-014 Valid request: wbs_stb_i & wbs_cyc_i & wbs_adr_i[31:24]==BASE; idx = wbs_adr_i[SEL_LSB+3:SEL_LSB].
REQ-015 Target decode: idx<NUM_SLAVES -> slave idx; idx==15 -> internal CSR; otherwise unmapped.
REQ-016 FSM states IDLE, FWD, RESP; reset state IDLE.
REQ-017 IDLE: valid request latches idx and we; slave -> FWD; CSR or unmapped -> RESP; else stay.
REQ-018 FWD: m_wbs_stb_o[idx] = wbs_stb_i & wbs_cyc_i; all other bits 0; m_wbs_stb_o is all-zero outside FWD.
REQ-019 FWD: m_wbs_ack_i[idx] high -> capture m_wbs_dat_i slice into response register, go RESP.
REQ-020 FWD: 10-bit counter cleared on entry, +1 per FWD cycle; after TIMEOUT FWD cycles with no ack -> RESP, data 32'hDEAD_DEAD, set STATUS.TO, record idx.
REQ-021 Ack and timeout in the same cycle: ack wins; flag is not set.
REQ-022 FWD with wbs_cyc_i low: abort to IDLE, no wbs_ack_o, no flag.
REQ-023 RESP: wbs_ack_o high for exactly one cycle with registered wbs_dat_o; next state IDLE; wbs_dat_o is 0 whenever wbs_ack_o is low.
REQ-024 Latency: slave ack in cycle k -> wbs_ack_o in cycle k+1; CSR/unmapped ack one cycle after acceptance; timeout ack TIMEOUT+1 cycles after acceptance.
REQ-025 m_wbs_ack_i bits of non-selected slaves, and any ack outside FWD, are ignored.
REQ-026 Unmapped access: read data 32'hBAD0_0000, writes discarded, STATUS.UM set.
REQ-027 CSR offset wbs_adr_i[3:2]: 0 SLV_RST (RW, NUM_SLAVES bits); 1 STATUS; 2 IRQ_EN (RW, 2 bits); 3 ID (RO).
REQ-028 STATUS: bit0 TO (W1C), bit1 UM (W1C), bits[11:8] last timed-out idx (RO).
REQ-029 ID reads {8'hA5, 8'd NUM_SLAVES, 16'h0001}.
REQ-030 CSR writes honour wbs_sel_i per byte lane; writes to RO bits and unused bits are ignored; unused bits read 0.
REQ-031 Flag set and W1C clear in the same cycle: set wins.
REQ-032 m_rst_o[i] = SLV_RST[i] | ~wb_rst_n_i; registered bits take effect the cycle after the write ack.
REQ-033 irq_o is registered: |(STATUS[1:0] & IRQ_EN[1:0]), one-cycle delay after the flag update.
REQ-034 Back-to-back: a valid request in the cycle after RESP is accepted without an idle gap.

Reset
REQ-035 wb_rst_n_i low asynchronously forces IDLE, wbs_ack_o=0, wbs_dat_o=0, m_wbs_stb_o=0, irq_o=0, counter=0, SLV_RST=0, STATUS=0, IRQ_EN=0, and m_rst_o all-ones.
REQ-036 Reset mid-transfer aborts with no ack; after release the first valid request is accepted normally.

Verification
REQ-037 Read 0x3000_3000; slave 3 acks in FWD cycle 2 with 32'h1234_5678 -> m_wbs_stb_o=11'h008 for 2 cycles; single wbs_ack_o with 32'h1234_5678 one cycle later.
REQ-038 Read slave 5, never ack, TIMEOUT=255, IRQ_EN=1 -> ack at cycle 256 with 32'hDEAD_DEAD; STATUS=32'h0000_0501; irq_o high next cycle; W1C 1 clears irq_o.
REQ-039 Write 0x3000_F000, data 32'h0000_0404, sel=4'b0001 -> SLV_RST=11'h004, m_rst_o=11'h004; write with sel=4'b0010 leaves it unchanged.
REQ-040 Read 0x3000_C000 (idx 12) -> ack next cycle, data 32'hBAD0_0000, STATUS.UM=1; read 0x3000_F00C -> 32'hA50B_0001.
REQ-041 Drop wbs_cyc_i in FWD cycle 3 -> no ack, m_wbs_stb_o=0 next cycle; repeat with wb_rst_n_i pulsed low in FWD -> all outputs at reset values immediately.
